sysctrl_arbiter: RTL and testbench
==================================

# sysctrl_arbiter

Two-requester arbiter and bus sequencer in front of the system control register bank (power-good status, clock/trap output routing, IRQ source select). It shares the bank's single iomem-style port between the management CPU (m0) and the housekeeping SPI (m1) with round-robin fairness. It also guards against hangs: the register bank silently ignores addresses outside its 256-byte window, so the arbiter terminates any unanswered access after a bounded time. It sits between the two masters' iomem adapters and the register bank's iomem port.

## Interface
- TIMEOUT, 16: cycles a granted access may wait for `s_ready` before forced termination (≥2).
- TIMEOUT_DATA, 32'hFFFF_FFFF: read data returned on a timed-out access.
- `clk` in 1: single clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `m0_addr`, `m1_addr` in 32: requester address.
- `m0_valid`, `m1_valid` in 1: request. Held until the matching `mX_ready`.
- `m0_wstrb`, `m1_wstrb` in 4: byte write strobes. 0 means read.
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m0_rdata`, `m1_rdata` out 32: read data. Valid when `mX_ready`=1.
- `m0_ready`, `m1_ready` out 1: one-cycle completion pulse.
- `s_addr` out 32, `s_valid` out 1, `s_wstrb` out 4, `s_wdata` out 32: to the register bank.
- `s_rdata` in 32, `s_ready` in 1: from the register bank.
- `timeout_flag` out 1: sticky; set when any access times out.
- `timeout_clr` in 1: synchronous clear of `timeout_flag`.
- `grant` out 2: one-hot current owner. Bit 0 = m0, bit 1 = m1. 0 when idle.

## Operation
- States:
  - IDLE: no owner.
  - GNT0: m0 owns the slave port.
  - GNT1: m1 owns the slave port.
- IDLE transitions:
  - Only one `mX_valid` set: go to GNTX.
  - Both set: grant the requester that is not `last`. `last` is a 1-bit register holding the most recent owner; reset value 1, so m0 wins the first tie.
- Port muxing:
  - In GNTX, `s_addr`/`s_wstrb`/`s_wdata`/`s_valid` are driven combinationally from mX.
  - In IDLE, all `s_*` outputs are 0.
  - The non-owner's `ready` is held 0; its request stays pending.
- Normal completion in GNTX:
  - `s_ready`=1 → `mX_ready`=1 and `mX_rdata`=`s_rdata` in the same cycle.
  - Next state IDLE; `last`←X.
- Abort:
  - Owner drops `mX_valid` before `s_ready` → IDLE next cycle; `last`←X.
  - No ready is issued.
  - A write may already have committed in the bank.
- Timeout:
  - A counter clears on grant and increments each GNTX cycle without `s_ready`.
  - When count == TIMEOUT−1 and `s_ready`=0: drive `s_valid`=0, `mX_ready`=1, `mX_rdata`=TIMEOUT_DATA, set `timeout_flag`. Next state IDLE; `last`←X.
  - `s_ready` and the timeout condition in the same cycle: the normal completion wins and the flag is not set.
- `timeout_flag`: if a set and `timeout_clr` occur in the same cycle, set wins.
- `rdata` outputs are 0 whenever the corresponding `ready` is 0.

## Timing
- Reset (async assert, deassertion synchronized externally):
  - State IDLE, `last`=1, counter 0, `timeout_flag`=0, `grant`=0.
  - All `mX_ready`, `mX_rdata`, and `s_*` outputs 0.
- Reset mid-access: the access is dropped with no ready pulse; the requester must reissue.
- Grant latency: `mX_valid` rising in cycle n (IDLE) → `grant`/`s_valid` asserted in cycle n+1.
- Round trip with the standard bank (registered ready): `s_ready` in n+2, so `mX_ready` in n+2.
- One IDLE cycle follows every completion, so back-to-back accesses from either requester are 3 cycles apart minimum.
- Timeout: `mX_ready` is asserted exactly TIMEOUT cycles after grant (grant cycle counted as 1).
- Starvation bound: under continuous contention, a pending requester is granted within one access time (≤ TIMEOUT+1 cycles).

## Structure
- `sysctrl_pkg`: state encodings (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and the TIMEOUT_DATA default, shared with future sysctrl bus blocks.
- Sub-module `sysctrl_arb_timeout`: counter, width $clog2(TIMEOUT). Inputs `clr`, `en`, `s_ready`; output `expire`.
- The FSM, `last` register, and port muxes live in the top module.

## Test plan
- m0 reads 0x2300_0004 with bank ready at +1 → `m0_ready` in cycle n+2 with bank data; `grant` sequence 01→00.
- m0 and m1 valid together after reset → m0 served first, then m1 after one IDLE cycle. Repeat tie → m1 first (alternation).
- m1 writes 0x2300_0008 with `wstrb`=4'h1, `wdata`=1 → bank sees that `s_addr`/`s_wstrb`/`s_wdata` while `grant`=10. m0 held off with `m0_ready`=0 throughout.
- m0 accesses 0x2300_0100 (bank never responds), TIMEOUT=16 → `m0_ready` 16 cycles after grant with `rdata`=FFFF_FFFF. `timeout_flag`=1 until `timeout_clr`. A clear in the same cycle as a new timeout leaves the flag at 1.
- `s_ready` arrives exactly at count 15 → normal data returned and flag stays 0.
- `resetn` asserted while GNT1 waits → outputs 0 immediately, no `m1_ready`. After release, a tie grants m0.

Source files
------------

// File: rtl/sysctrl_pkg.sv
// sysctrl_pkg: shared encodings and defaults for the sysctrl bus blocks.
package sysctrl_pkg;

    // Arbiter ownership states; the encoding is fixed so debug tooling can decode it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    // Read data handed back when an access is terminated for lack of a bank response.
    localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hFFFF_FFFF;

    // Default number of granted cycles before an unanswered access is forced to complete.
    localparam int TIMEOUT_DEFAULT = 16;

    // One-hot owner vector for a given state (bit 0 = m0, bit 1 = m1).
    function automatic logic [1:0] state_to_grant(arb_state_e st);
        logic [1:0] g;
        g = 2'b00;
        case (st)
            ST_GNT0: g = 2'b01;
            ST_GNT1: g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/sysctrl_arb_timeout.sv
// sysctrl_arb_timeout: counts granted cycles without a bank response and flags
// the cycle in which the access must be forced to complete.
module sysctrl_arb_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    input  logic s_ready,
    output logic expire
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear while idle, advance on every unanswered owned cycle, hold at the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !s_ready && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A bank response in the final cycle takes precedence over expiry.
    assign expire = en && !s_ready && (cnt_q == LAST);

endmodule

// File: rtl/sysctrl_arbiter.sv
// sysctrl_arbiter: round-robin arbiter between the management CPU (m0) and the
// housekeeping SPI (m1) in front of the sysctrl register bank iomem port, with a
// bounded-wait timeout for accesses the bank never answers.
//
// Handshake: a master raises mX_valid with stable addr/wstrb/wdata and holds it
// until mX_ready pulses for one cycle (rdata valid only in that cycle, 0 otherwise).
// Dropping mX_valid before mX_ready abandons the access without a ready pulse.
// Toward the bank, s_valid is held while the owner waits; s_ready completes the
// access in the same cycle. One idle cycle always follows a completion.
module sysctrl_arbiter
    import sysctrl_pkg::*;
#(
    parameter int          TIMEOUT      = TIMEOUT_DEFAULT,
    parameter logic [31:0] TIMEOUT_DATA = TIMEOUT_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] m0_addr,
    input  logic        m0_valid,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    input  logic [31:0] m1_addr,
    input  logic        m1_valid,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic [31:0] s_addr,
    output logic        s_valid,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,
    output logic        timeout_flag,
    input  logic        timeout_clr,
    output logic [1:0]  grant,
    output logic [1:0]  state_dbg
);

    arb_state_e  state_q;
    arb_state_e  state_d;
    logic        last_q;
    logic        last_d;
    logic        flag_q;
    logic        flag_d;
    logic        to_set;
    logic        expire;
    logic        owned;
    logic        own_m1;
    logic        own_valid;
    logic [31:0] own_addr;
    logic [3:0]  own_wstrb;
    logic [31:0] own_wdata;
    logic [31:0] done_rdata;

    sysctrl_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (!owned),
        .en      (owned),
        .s_ready (s_ready),
        .expire  (expire)
    );

    // Select the current owner's request fields.
    always_comb begin
        owned     = (state_q == ST_GNT0) || (state_q == ST_GNT1);
        own_m1    = (state_q == ST_GNT1);
        own_valid = own_m1 ? m1_valid : m0_valid;
        own_addr  = own_m1 ? m1_addr  : m0_addr;
        own_wstrb = own_m1 ? m1_wstrb : m0_wstrb;
        own_wdata = own_m1 ? m1_wdata : m0_wdata;
    end

    // Next-state, round-robin choice, bank port mux and completion/timeout responses.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        to_set     = 1'b0;
        done_rdata = s_ready ? s_rdata : TIMEOUT_DATA;
        s_addr     = '0;
        s_valid    = 1'b0;
        s_wstrb    = '0;
        s_wdata    = '0;
        m0_ready   = 1'b0;
        m1_ready   = 1'b0;
        m0_rdata   = '0;
        m1_rdata   = '0;
        case (state_q)
            ST_IDLE: begin
                if (m0_valid && m1_valid) begin
                    // Tie: the requester that did not own the port most recently wins.
                    state_d = last_q ? ST_GNT0 : ST_GNT1;
                end else if (m0_valid) begin
                    state_d = ST_GNT0;
                end else if (m1_valid) begin
                    state_d = ST_GNT1;
                end
            end
            ST_GNT0, ST_GNT1: begin
                s_addr  = own_addr;
                s_wstrb = own_wstrb;
                s_wdata = own_wdata;
                // Withdraw the request from the bank in the cycle it is timed out.
                s_valid = own_valid && !expire;
                if (!own_valid) begin
                    // Owner abandoned the access; no ready pulse is issued.
                    state_d = ST_IDLE;
                    last_d  = own_m1;
                end else if (s_ready || expire) begin
                    if (own_m1) begin
                        m1_ready = 1'b1;
                        m1_rdata = done_rdata;
                    end else begin
                        m0_ready = 1'b1;
                        m0_rdata = done_rdata;
                    end
                    to_set  = !s_ready;
                    state_d = ST_IDLE;
                    last_d  = own_m1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A new timeout beats a simultaneous clear.
        flag_d = to_set ? 1'b1 : (timeout_clr ? 1'b0 : flag_q);
    end

    // FSM state, last-owner and sticky timeout flag registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            flag_q  <= flag_d;
        end
    end

    assign timeout_flag = flag_q;
    assign grant        = state_to_grant(state_q);
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_sysctrl_arbiter.sv
// tb_sysctrl_arbiter: directed checks of arbitration order, port muxing, abort,
// timeout, flag handling and mid-access reset for sysctrl_arbiter.
module tb_sysctrl_arbiter;

    localparam int TIMEOUT  = 16;
    localparam int BM_RESP1 = 0;
    localparam int BM_NEVER = 1;
    localparam int BM_AT    = 2;

    logic        clk;
    logic        resetn;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic        m0_valid, m1_valid, m0_ready, m1_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_valid, s_ready;
    logic        timeout_flag, timeout_clr;
    logic [1:0]  grant, state_dbg;

    int          checks   = 0;
    int          failures = 0;
    logic [32:0] exp_q[$];
    int          bank_mode = BM_RESP1;
    int          at_k      = 15;

    sysctrl_arbiter #(
        .TIMEOUT      (TIMEOUT),
        .TIMEOUT_DATA (32'hFFFF_FFFF)
    ) dut (
        .clk (clk), .resetn (resetn),
        .m0_addr (m0_addr), .m0_valid (m0_valid), .m0_wstrb (m0_wstrb), .m0_wdata (m0_wdata),
        .m0_rdata (m0_rdata), .m0_ready (m0_ready),
        .m1_addr (m1_addr), .m1_valid (m1_valid), .m1_wstrb (m1_wstrb), .m1_wdata (m1_wdata),
        .m1_rdata (m1_rdata), .m1_ready (m1_ready),
        .s_addr (s_addr), .s_valid (s_valid), .s_wstrb (s_wstrb), .s_wdata (s_wdata),
        .s_rdata (s_rdata), .s_ready (s_ready),
        .timeout_flag (timeout_flag), .timeout_clr (timeout_clr),
        .grant (grant), .state_dbg (state_dbg)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Register bank model: samples the port at negedge, answers just after posedge.
    initial begin
        logic        sv, sr;
        logic [31:0] sa;
        int          cnt;
        s_ready = 1'b0;
        s_rdata = 32'hDEAD_BEEF;
        cnt     = 0;
        forever begin
            @(negedge clk);
            sv = s_valid;
            sr = s_ready;
            sa = s_addr;
            if (s_valid && !s_ready) cnt++;
            else cnt = 0;
            @(posedge clk);
            #1;
            case (bank_mode)
                BM_RESP1: s_ready = sv && !sr;
                BM_AT:    s_ready = sv && (cnt == at_k);
                default:  s_ready = 1'b0;
            endcase
            s_rdata = s_ready ? (sa ^ 32'hCAFE_0000) : 32'hDEAD_BEEF;
        end
    end

    // Scoreboard monitor: every ready pulse pops one expected {owner, rdata}.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (m0_ready && m1_ready) chk("both_ready", 32'(m1_ready), 32'd0);
            if (!m0_ready) chk("m0_rdata_idle", m0_rdata, 32'd0);
            if (!m1_ready) chk("m1_rdata_idle", m1_rdata, 32'd0);
            if (m0_ready) begin
                if (exp_q.size() == 0) chk("m0_unexpected_ready", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("m0_owner", 32'd0, 32'(e[32]));
                    chk("m0_rsp", m0_rdata, e[31:0]);
                end
            end
            if (m1_ready) begin
                if (exp_q.size() == 0) chk("m1_unexpected_ready", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("m1_owner", 32'd1, 32'(e[32]));
                    chk("m1_rsp", m1_rdata, e[31:0]);
                end
            end
        end
    end

    // Steps n cycles checking grant against seq (2 bits per cycle), releasing
    // each master's valid after its ready pulse.
    task automatic run_seq(input string name, input logic [31:0] seq, input int n);
        logic r0, r1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(name, 32'(grant), 32'(seq[2*i +: 2]));
            r0 = m0_ready;
            r1 = m1_ready;
            tick();
            if (r0) m0_valid = 1'b0;
            if (r1) m1_valid = 1'b0;
        end
        m0_valid = 1'b0;
        m1_valid = 1'b0;
    endtask

    // m0 access toward an unanswered or late bank; returns the ready cycle
    // (cycle 0 = request cycle) and s_valid seen in that cycle.
    task automatic run_timeout(input logic [31:0] addr, input bit clr_at_expire,
                               output int rc, output logic sv_at);
        rc       = -1;
        sv_at    = 1'bx;
        m0_addr  = addr;
        m0_wstrb = 4'h0;
        m0_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m0_ready) begin
                rc    = c;
                sv_at = s_valid;
            end
            tick();
            timeout_clr = clr_at_expire && (c + 1 == TIMEOUT);
            if (rc >= 0) break;
        end
        m0_valid    = 1'b0;
        timeout_clr = 1'b0;
    endtask

    // Stimulus
    initial begin
        int   rc;
        logic sv_at;
        resetn = 1'b0;
        m0_addr = '0; m0_valid = 1'b0; m0_wstrb = '0; m0_wdata = '0;
        m1_addr = '0; m1_valid = 1'b0; m1_wstrb = '0; m1_wdata = '0;
        timeout_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
        chk("rst_flag", 32'(timeout_flag), 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        // Tie after reset: m0 first, then m1 after one idle cycle.
        bank_mode = BM_RESP1;
        m0_addr = 32'h2300_0010; m1_addr = 32'h2300_0014;
        m0_valid = 1'b1; m1_valid = 1'b1;
        exp_q.push_back({1'b0, 32'hE9FE_0010});
        exp_q.push_back({1'b1, 32'hE9FE_0014});
        run_seq("tie1_grant", 32'hA14, 7);

        // Single m0 read: grant 00,01,01(ready),00.
        m0_addr = 32'h2300_0004; m0_valid = 1'b1;
        exp_q.push_back({1'b0, 32'hE9FE_0004});
        run_seq("m0_read_grant", 32'h14, 4);

        // Tie again after m0 was last: m1 first.
        m0_addr = 32'h2300_0018; m1_addr = 32'h2300_001C;
        m0_valid = 1'b1; m1_valid = 1'b1;
        exp_q.push_back({1'b1, 32'hE9FE_001C});
        exp_q.push_back({1'b0, 32'hE9FE_0018});
        run_seq("tie2_grant", 32'h528, 7);

        // m1 write with m0 arriving while m1 owns the port.
        m1_addr = 32'h2300_0008; m1_wstrb = 4'h1; m1_wdata = 32'h1; m1_valid = 1'b1;
        exp_q.push_back({1'b1, 32'hE9FE_0008});
        exp_q.push_back({1'b0, 32'hE9FE_0020});
        @(negedge clk);
        chk("wr_grant0", 32'(grant), 32'd0);
        tick();
        m0_addr = 32'h2300_0020; m0_valid = 1'b1;
        @(negedge clk);
        chk("wr_grant1", 32'(grant), 32'd2);
        chk("wr_s_addr", s_addr, 32'h2300_0008);
        chk("wr_s_wstrb", 32'(s_wstrb), 32'h1);
        chk("wr_s_wdata", s_wdata, 32'h1);
        chk("wr_s_valid", 32'(s_valid), 32'd1);
        chk("wr_m0_held", 32'(m0_ready), 32'd0);
        tick();
        run_seq("wr_then_m0_grant", 32'h52, 5);
        m1_wstrb = 4'h0; m1_wdata = '0;

        // Abort: m1 drops valid before the bank answers.
        bank_mode = BM_NEVER;
        m1_addr = 32'h2300_0030; m1_valid = 1'b1;
        tick();
        @(negedge clk);
        chk("abort_grant", 32'(grant), 32'd2);
        tick();
        m1_valid = 1'b0;
        @(negedge clk);
        chk("abort_s_valid", 32'(s_valid), 32'd0);
        chk("abort_no_ready", 32'(m1_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("abort_idle", 32'(grant), 32'd0);
        tick();

        // Timeout against a silent address.
        chk("flag_pre", 32'(timeout_flag), 32'd0);
        exp_q.push_back({1'b0, 32'hFFFF_FFFF});
        run_timeout(32'h2300_0100, 1'b0, rc, sv_at);
        chk("to_cycle", 32'(rc), 32'd16);
        chk("to_s_valid", 32'(sv_at), 32'd0);
        @(negedge clk);
        chk("to_flag_set", 32'(timeout_flag), 32'd1);
        tick(); tick();
        @(negedge clk);
        chk("to_flag_sticky", 32'(timeout_flag), 32'd1);
        tick();
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0;
        @(negedge clk);
        chk("to_flag_clr", 32'(timeout_flag), 32'd0);
        tick();

        // Clear in the same cycle as a new timeout: flag ends set.
        exp_q.push_back({1'b0, 32'hFFFF_FFFF});
        run_timeout(32'h2300_0104, 1'b1, rc, sv_at);
        chk("to2_cycle", 32'(rc), 32'd16);
        @(negedge clk);
        chk("to2_set_wins", 32'(timeout_flag), 32'd1);
        tick();
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0;
        @(negedge clk);
        chk("to2_flag_clr", 32'(timeout_flag), 32'd0);
        tick();

        // Bank answers exactly at count 15: normal data, no flag.
        bank_mode = BM_AT;
        at_k = 15;
        exp_q.push_back({1'b0, 32'hE9FE_0040});
        run_timeout(32'h2300_0040, 1'b0, rc, sv_at);
        chk("late_cycle", 32'(rc), 32'd16);
        chk("late_s_valid", 32'(sv_at), 32'd1);
        @(negedge clk);
        chk("late_flag", 32'(timeout_flag), 32'd0);
        tick();

        // Reset while m1 waits in GNT1.
        bank_mode = BM_NEVER;
        m1_addr = 32'h2300_0050; m1_valid = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rst_mid_pre", 32'(grant), 32'd2);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_mid_grant", 32'(grant), 32'd0);
        chk("rst_mid_state", 32'(state_dbg), 32'd0);
        chk("rst_mid_s_valid", 32'(s_valid), 32'd0);
        chk("rst_mid_s_addr", s_addr, 32'd0);
        chk("rst_mid_ready", 32'(m1_ready), 32'd0);
        m1_valid = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        tick();
        bank_mode = BM_RESP1;
        m0_addr = 32'h2300_0060; m1_addr = 32'h2300_0064;
        m0_valid = 1'b1; m1_valid = 1'b1;
        exp_q.push_back({1'b0, 32'hE9FE_0060});
        exp_q.push_back({1'b1, 32'hE9FE_0064});
        run_seq("post_rst_tie", 32'hA14, 7);

        repeat (3) tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
